alu_exec_unit: RTL and testbench
================================

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning operand/result/register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, meaning register address width (2**ADDR_WIDTH registers).
REQ-003 SHALL have port i_CLK  input  1  clock; all state changes on its rising edge.
REQ-004 SHALL have port i_RSTn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_oper  input  2  operation code: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-006 SHALL have port i_valid  input  1  issue request from the control unit.
REQ-007 SHALL have port o_ready  output  1  unit can accept an issue this cycle.
REQ-008 SHALL have ports i_reg0_addr, i_reg1_addr  input  ADDR_WIDTH  source operand A and B addresses.
REQ-009 SHALL have port i_reg2_addr  input  ADDR_WIDTH  destination address.
REQ-010 SHALL have ports i_ld_en  input  1, i_ld_addr  input  ADDR_WIDTH, i_ld_data  input  DATA_WIDTH  register preload port.
REQ-011 SHALL have ports o_wb_valid  output  1, o_wb_addr  output  ADDR_WIDTH, o_wb_data  output  DATA_WIDTH  write-back report.
REQ-012 SHALL have ports o_zero, o_carry  output  1  flags of the last write-back.
REQ-013 SHALL have ports i_dbg_addr  input  ADDR_WIDTH, o_dbg_data  output  DATA_WIDTH  combinational register-file read.

Function
REQ-014 SHALL contain a register file of 2**ADDR_WIDTH x DATA_WIDTH entries; register 0 always reads 0 and is never written.
REQ-015 SHALL implement FSM states IDLE, EXEC, WB; o_ready = 1 only in IDLE.
REQ-016 SHALL accept an issue on a rising edge where state = IDLE and i_valid = 1: latch i_oper, i_reg2_addr, regfile[i_reg0_addr] into A and regfile[i_reg1_addr] into B; go to EXEC.
REQ-017 SHALL ignore i_valid in EXEC and WB; no operands or addresses are sampled there.
REQ-018 SHALL in EXEC compute the result into a result register: ADD A+B, SUB A-B, AND A&B, OR A|B, truncated to DATA_WIDTH; go to WB.
REQ-019 SHALL compute carry as the ADD carry-out, the SUB borrow (1 when A < B unsigned), and 0 for AND/OR.
REQ-020 SHALL in WB drive o_wb_valid = 1 for exactly one cycle with o_wb_addr = latched destination and o_wb_data = result, and on the edge leaving WB write the result into the register file when the destination is nonzero, update o_zero (result == 0) and o_carry, and return to IDLE.
REQ-021 SHALL report write-back with destination 0 (o_wb_valid = 1, flags updated) without modifying the register file.
REQ-022 SHALL give a fixed latency: issue accepted at edge N, o_wb_valid high in the cycle after edge N+1, register updated at edge N+2, o_ready high again after edge N+2; peak throughput one issue per 3 cycles.
REQ-023 SHALL write i_ld_data to i_ld_addr on any edge with i_ld_en = 1 and i_ld_addr != 0, in any state.
REQ-024 SHALL give write-back priority over the preload when both target the same address on the same edge; different addresses are both written.
REQ-025 SHALL make an operand read at issue see the register-file contents before that edge (no same-edge bypass of the preload).
REQ-026 SHALL hold o_wb_addr and o_wb_data at their last values and o_wb_valid = 0 outside WB.

Reset
REQ-027 SHALL on i_RSTn = 0 immediately force state IDLE, clear all registers, A, B, result, latched oper and destination; o_wb_valid = 0, o_wb_addr = 0, o_wb_data = 0, o_zero = 0, o_carry = 0.
REQ-028 SHALL drive o_ready = 0 while i_RSTn = 0 and 1 from the first rising edge after release.
REQ-029 SHALL abandon an in-flight operation when reset is asserted during EXEC or WB, with no register write and no o_wb_valid pulse.

Verification
REQ-030 SHALL pass: preload r1 = 5 and r2 = 3, issue ADD r3 <- r1,r2 -> o_wb_valid one cycle with addr 3 and data 8; dbg r3 = 8; zero = 0, carry = 0.
REQ-031 SHALL pass: r1 = 3, r2 = 5, SUB r4 <- r1,r2 -> data 0xFFFFFFFE, carry = 1; with r1 = r2 = 7 -> data 0, zero = 1.
REQ-032 SHALL pass: r1 = 0xFFFFFFFF, r2 = 1, ADD r5 -> data 0, zero = 1, carry = 1; AND/OR of 0xF0F0 and 0x0FF0 -> 0x00F0 and 0xFFF0, carry = 0.
REQ-033 SHALL pass: i_valid held high continuously -> o_ready pattern 1,0,0 repeating; exactly one write-back per 3 cycles; a write to r0 leaves dbg r0 = 0.
REQ-034 SHALL pass: preload of r3 = 0x55 on the same edge as write-back of 0xAA to r3 -> r3 = 0xAA.
REQ-035 SHALL pass: reset asserted during EXEC -> no o_wb_valid pulse, all dbg reads = 0, o_ready = 1 one cycle after release.

Source files
------------

// File: rtl/alu_exec_unit.sv
// ============================================================================
// alu_exec_unit : three-cycle ALU execution unit with register file,
//                 preload port, write-back report and debug read port.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module alu_exec_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  i_CLK,
   input  logic                  i_RSTn,
   input  logic [1:0]            i_oper,
   input  logic                  i_valid,
   output logic                  o_ready,
   input  logic [ADDR_WIDTH-1:0] i_reg0_addr,
   input  logic [ADDR_WIDTH-1:0] i_reg1_addr,
   input  logic [ADDR_WIDTH-1:0] i_reg2_addr,
   input  logic                  i_ld_en,
   input  logic [ADDR_WIDTH-1:0] i_ld_addr,
   input  logic [DATA_WIDTH-1:0] i_ld_data,
   output logic                  o_wb_valid,
   output logic [ADDR_WIDTH-1:0] o_wb_addr,
   output logic [DATA_WIDTH-1:0] o_wb_data,
   output logic                  o_zero,
   output logic                  o_carry,
   input  logic [ADDR_WIDTH-1:0] i_dbg_addr,
   output logic [DATA_WIDTH-1:0] o_dbg_data
);

   localparam int NREGS = 2 ** ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   state_t                  state_q, state_d;
   logic                    boot_q, boot_d;
   logic [1:0]              oper_q, oper_d;
   logic [ADDR_WIDTH-1:0]   dst_q, dst_d;
   logic [ADDR_WIDTH-1:0]   wb_addr_q, wb_addr_d;
   logic [DATA_WIDTH-1:0]   a_q, a_d;
   logic [DATA_WIDTH-1:0]   b_q, b_d;
   logic [DATA_WIDTH-1:0]   res_q, res_d;
   logic                    cy_q, cy_d;
   logic                    zero_q, zero_d;
   logic                    carry_q, carry_d;
   logic [DATA_WIDTH-1:0]   rf_q [NREGS];
   logic [DATA_WIDTH-1:0]   rf_d [NREGS];

   logic [DATA_WIDTH:0]     alu_sum;
   logic [DATA_WIDTH:0]     alu_diff;
   logic [DATA_WIDTH-1:0]   alu_res;
   logic                    alu_cy;

   // The extra top bit of the widened difference is the unsigned borrow.
   always_comb begin
      alu_sum  = {1'b0, a_q} + {1'b0, b_q};
      alu_diff = {1'b0, a_q} - {1'b0, b_q};
      alu_res  = '0;
      alu_cy   = 1'b0;
      case (oper_q)
         2'b00: begin
            alu_res = alu_sum[DATA_WIDTH-1:0];
            alu_cy  = alu_sum[DATA_WIDTH];
         end
         2'b01: begin
            alu_res = alu_diff[DATA_WIDTH-1:0];
            alu_cy  = alu_diff[DATA_WIDTH];
         end
         2'b10:   alu_res = a_q & b_q;
         default: alu_res = a_q | b_q;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      boot_d    = 1'b1;
      oper_d    = oper_q;
      dst_d     = dst_q;
      wb_addr_d = wb_addr_q;
      a_d       = a_q;
      b_d       = b_q;
      res_d     = res_q;
      cy_d      = cy_q;
      zero_d    = zero_q;
      carry_d   = carry_q;
      rf_d      = rf_q;

      case (state_q)
         IDLE: begin
            if (i_valid && boot_q) begin
               oper_d  = i_oper;
               dst_d   = i_reg2_addr;
               a_d     = rf_q[i_reg0_addr];
               b_d     = rf_q[i_reg1_addr];
               state_d = EXEC;
            end
         end
         EXEC: begin
            res_d     = alu_res;
            cy_d      = alu_cy;
            wb_addr_d = dst_q;
            state_d   = WB;
         end
         WB: begin
            zero_d  = (res_q == '0);
            carry_d = cy_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Write-back is applied last so it wins over a same-address preload.
      if (i_ld_en && (i_ld_addr != '0)) rf_d[i_ld_addr] = i_ld_data;
      if ((state_q == WB) && (wb_addr_q != '0)) rf_d[wb_addr_q] = res_q;
   end

   always_ff @(posedge i_CLK or negedge i_RSTn) begin
      if (!i_RSTn) begin
         state_q   <= IDLE;
         boot_q    <= 1'b0;
         oper_q    <= '0;
         dst_q     <= '0;
         wb_addr_q <= '0;
         a_q       <= '0;
         b_q       <= '0;
         res_q     <= '0;
         cy_q      <= 1'b0;
         zero_q    <= 1'b0;
         carry_q   <= 1'b0;
         for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         boot_q    <= boot_d;
         oper_q    <= oper_d;
         dst_q     <= dst_d;
         wb_addr_q <= wb_addr_d;
         a_q       <= a_d;
         b_q       <= b_d;
         res_q     <= res_d;
         cy_q      <= cy_d;
         zero_q    <= zero_d;
         carry_q   <= carry_d;
         for (int i = 0; i < NREGS; i++) rf_q[i] <= rf_d[i];
      end
   end

   assign o_ready    = (state_q == IDLE) && boot_q;
   assign o_wb_valid = (state_q == WB);
   assign o_wb_addr  = wb_addr_q;
   assign o_wb_data  = res_q;
   assign o_zero     = zero_q;
   assign o_carry    = carry_q;
   assign o_dbg_data = rf_q[i_dbg_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// ============================================================================
// tb_alu_exec_unit : randomized + directed scoreboard bench for alu_exec_unit.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_alu_exec_unit;

   logic        i_CLK = 1'b0;
   logic        i_RSTn = 1'b1;
   logic [1:0]  i_oper = '0;
   logic        i_valid = 1'b0;
   logic        o_ready;
   logic [4:0]  i_reg0_addr = '0, i_reg1_addr = '0, i_reg2_addr = '0;
   logic        i_ld_en = 1'b0;
   logic [4:0]  i_ld_addr = '0;
   logic [31:0] i_ld_data = '0;
   logic        o_wb_valid;
   logic [4:0]  o_wb_addr;
   logic [31:0] o_wb_data;
   logic        o_zero, o_carry;
   logic [4:0]  i_dbg_addr = '0;
   logic [31:0] o_dbg_data;

   alu_exec_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
      .i_CLK(i_CLK), .i_RSTn(i_RSTn), .i_oper(i_oper), .i_valid(i_valid),
      .o_ready(o_ready), .i_reg0_addr(i_reg0_addr), .i_reg1_addr(i_reg1_addr),
      .i_reg2_addr(i_reg2_addr), .i_ld_en(i_ld_en), .i_ld_addr(i_ld_addr),
      .i_ld_data(i_ld_data), .o_wb_valid(o_wb_valid), .o_wb_addr(o_wb_addr),
      .o_wb_data(o_wb_data), .o_zero(o_zero), .o_carry(o_carry),
      .i_dbg_addr(i_dbg_addr), .o_dbg_data(o_dbg_data)
   );

   always #5 i_CLK = ~i_CLK;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      logic        z;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;

   // Reference model state
   logic [31:0] m [32];
   int          ph = 0;          // 0 idle, 1 computing, 2 reporting
   bit          boot = 0;
   logic [4:0]  cur_dst;
   logic [31:0] cur_res;
   bit          flag_pend = 0;
   logic        pz, pc;
   logic        exp_zero = 0, exp_carry = 0;

   always @(posedge i_CLK) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: flags settle on the edge after the report, then get compared.
   always @(negedge i_CLK) begin
      exp_t e;
      if (flag_pend) begin
         exp_zero  = pz;
         exp_carry = pc;
         flag_pend = 0;
      end
      chk("zero_flag", {63'd0, o_zero}, {63'd0, exp_zero});
      chk("carry_flag", {63'd0, o_carry}, {63'd0, exp_carry});
      if (o_wb_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("wb_spurious", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            chk("wb_addr", {59'd0, o_wb_addr}, {59'd0, e.addr});
            chk("wb_data", {32'd0, o_wb_data}, {32'd0, e.data});
            chk("wb_latency", 64'(cyc), 64'(e.cyc));
            pz = e.z;
            pc = e.c;
            flag_pend = 1;
         end
      end
   end

   // One clock of stimulus, starting just after a falling edge.
   task automatic step(input bit v, input logic [1:0] op, input logic [4:0] a0,
                       input logic [4:0] a1, input logic [4:0] a2, input bit le,
                       input logic [4:0] la, input logic [31:0] ld, input logic [4:0] dbg);
      exp_t        e;
      longint      full;
      bit          wb_now;
      i_valid = v;  i_oper = op;
      i_reg0_addr = a0;  i_reg1_addr = a1;  i_reg2_addr = a2;
      i_ld_en = le;  i_ld_addr = la;  i_ld_data = ld;  i_dbg_addr = dbg;
      #1;
      chk("ready", {63'd0, o_ready}, {63'd0, (ph == 0 && boot)});
      chk("dbg_read", {32'd0, o_dbg_data}, {32'd0, m[dbg]});
      wb_now = (ph == 2);
      if (ph == 0 && boot && v) begin
         case (op)
            2'd0: begin full = longint'(m[a0]) + longint'(m[a1]);
                        e.data = full[31:0]; e.c = (full > 64'hFFFF_FFFF); end
            2'd1: begin e.data = m[a0] - m[a1]; e.c = (m[a0] < m[a1]); end
            2'd2: begin e.data = m[a0] & m[a1]; e.c = 0; end
            default: begin e.data = m[a0] | m[a1]; e.c = 0; end
         endcase
         e.addr = a2;
         e.z    = (e.data == 0);
         e.cyc  = cyc + 2;
         sb.push_back(e);
         cur_dst = a2;
         cur_res = e.data;
         ph = 1;
      end else if (ph == 1) begin
         ph = 2;
      end else if (ph == 2) begin
         ph = 0;
      end
      @(posedge i_CLK);
      boot = 1;
      if (le && la != 0) m[la] = ld;
      if (wb_now && cur_dst != 0) m[cur_dst] = cur_res;
      @(negedge i_CLK);
   endtask

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      step(0, 2'd0, 5'd0, 5'd0, 5'd0, 1, a, d, a);
   endtask

   task automatic issue(input logic [1:0] op, input logic [4:0] d, input logic [4:0] a,
                        input logic [4:0] b);
      step(1, op, a, b, d, 0, 5'd0, 32'd0, d);
      step(0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, d);
      step(0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, d);
   endtask

   task automatic idle(input logic [4:0] dbg);
      step(0, 2'd0, 5'd0, 5'd0, 5'd0, 0, 5'd0, 32'd0, dbg);
   endtask

   // Called just after a falling edge; leaves the bench just after a falling edge.
   task automatic do_reset();
      #2;
      i_RSTn = 0;  i_valid = 0;  i_ld_en = 0;
      for (int i = 0; i < 32; i++) m[i] = '0;
      ph = 0;  boot = 0;  sb.delete();
      flag_pend = 0;  exp_zero = 0;  exp_carry = 0;
      #1;
      chk("rst_ready", {63'd0, o_ready}, 64'd0);
      chk("rst_wb_valid", {63'd0, o_wb_valid}, 64'd0);
      chk("rst_wb_addr", {59'd0, o_wb_addr}, 64'd0);
      chk("rst_wb_data", {32'd0, o_wb_data}, 64'd0);
      for (int a = 0; a < 32; a++) begin
         i_dbg_addr = a[4:0];
         #1;
         chk("rst_dbg", {32'd0, o_dbg_data}, 64'd0);
      end
      @(negedge i_CLK);
      #1 i_RSTn = 1;
      #1 chk("ready_before_edge", {63'd0, o_ready}, 64'd0);
      @(posedge i_CLK);
      boot = 1;
      #1 chk("ready_after_edge", {63'd0, o_ready}, 64'd1);
      @(negedge i_CLK);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired actual=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 32; i++) m[i] = '0;
      @(negedge i_CLK);
      do_reset();

      // Basic ADD, SUB borrow, SUB equal, ADD overflow, AND/OR
      preload(5'd1, 32'd5);  preload(5'd2, 32'd3);
      issue(2'd0, 5'd3, 5'd1, 5'd2);  idle(5'd3);
      preload(5'd1, 32'd3);  preload(5'd2, 32'd5);
      issue(2'd1, 5'd4, 5'd1, 5'd2);  idle(5'd4);
      preload(5'd1, 32'd7);  preload(5'd2, 32'd7);
      issue(2'd1, 5'd4, 5'd1, 5'd2);  idle(5'd4);
      preload(5'd1, 32'hFFFF_FFFF);  preload(5'd2, 32'd1);
      issue(2'd0, 5'd5, 5'd1, 5'd2);  idle(5'd5);
      preload(5'd1, 32'h0000_F0F0);  preload(5'd2, 32'h0000_0FF0);
      issue(2'd2, 5'd6, 5'd1, 5'd2);
      issue(2'd3, 5'd7, 5'd1, 5'd2);  idle(5'd7);

      // Destination r0 is reported but never written
      issue(2'd3, 5'd0, 5'd1, 5'd2);  idle(5'd0);

      // Same-edge preload and write-back to r3: write-back wins
      preload(5'd1, 32'h50);  preload(5'd2, 32'h5A);
      step(1, 2'd0, 5'd1, 5'd2, 5'd3, 0, 5'd0, 32'd0, 5'd3);
      idle(5'd3);
      preload(5'd3, 32'h55);
      idle(5'd3);

      // Preload on the issue edge is not seen by the operand read
      step(1, 2'd0, 5'd8, 5'd8, 5'd9, 1, 5'd8, 32'h1234, 5'd8);
      idle(5'd9);  idle(5'd9);  idle(5'd9);

      // Back-to-back issues with i_valid held high
      for (int i = 0; i < 12; i++)
         step(1, 2'(i), 5'(i), 5'(i + 1), 5'(i + 10), 0, 5'd0, 32'd0, 5'(i + 10));

      // Randomized traffic
      for (int i = 0; i < 300; i++) begin
         logic [31:0] d;
         case ($urandom_range(0, 3))
            0: d = 32'd0;
            1: d = 32'hFFFF_FFFF;
            default: d = $urandom;
         endcase
         step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), d,
              5'($urandom_range(0, 7)));
      end
      idle(5'd0);  idle(5'd0);  idle(5'd0);

      // Reset while the operation is executing
      preload(5'd1, 32'd9);  preload(5'd2, 32'd4);
      step(1, 2'd0, 5'd1, 5'd2, 5'd3, 0, 5'd0, 32'd0, 5'd3);
      do_reset();
      idle(5'd3);  idle(5'd1);  idle(5'd0);

      chk("sb_drain", 64'(sb.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
